seq_mult_controller: RTL and testbench
======================================

// Module: seq_mult_controller
// PURPOSE
//  Moore FSM that sequences the shift-add sequential multiplier datapath:
//  product/multiplier shift registers, single-bit shift stages, adder enable.
//  Issues load, add and shift strobes and counts processed multiplier bits.
//  Accepts a start request and reports completion with a one-cycle done pulse.
//  Sits between the top-level start/done interface and the multiplier datapath.
// PARAMETERS
//  WIDTH    8                  operand width = number of multiplier bits processed
//  CNT_W    $clog2(WIDTH+1)    bit counter width (derived, not overridden)
// PORTS
//  clk      in   1       clock, all state updates on rising edge
//  rst      in   1       synchronous active-high reset
//  Start    in   1       start request, sampled in IDLE only
//  q0       in   1       LSB of datapath multiplier register (current bit)
//  q_zero   in   1       datapath: remaining multiplier bits all zero
//  Load     out  1       load operands, clear accumulator
//  Add      out  1       accumulate multiplicand into upper product
//  Shift    out  1       shift product/multiplier right one bit (all shift stages)
//  Busy     out  1       high in every state except IDLE
//  Done     out  1       one-cycle completion pulse
//  bit_cnt  out  CNT_W   multiplier bits shifted so far
// BEHAVIOUR
//  - One clock; reset synchronous, active-high; rst wins over every input.
//  - Reset: state=IDLE, bit_cnt=0; Load=Add=Shift=Busy=Done=0.
//  - States: IDLE, LOAD, EVAL, ADD, SHIFT, DONE. Outputs decoded from state only.
//  - IDLE: Start=1 -> LOAD, else stay. bit_cnt holds.
//  - LOAD: Load=1, bit_cnt<=0 -> EVAL.
//  - EVAL: no strobes. Datapath register already updated, so q0/q_zero valid.
//    bit_cnt==WIDTH -> DONE; else q0=1 -> ADD; else -> SHIFT.
//  - ADD: Add=1 -> SHIFT.
//  - SHIFT: Shift=1, bit_cnt<=bit_cnt+1 -> EVAL.
//  - DONE: Done=1 for exactly one cycle -> IDLE.
//  - Busy=1 in LOAD, EVAL, ADD, SHIFT, DONE.
//  - Latency: Start sampled at edge 0 -> Load in cycle 1.
//    Done in cycle 3 + 2*WIDTH + popcount(multiplier).
//  - Start while Busy ignored, no queuing. Start held high through DONE
//    restarts: IDLE samples it the cycle after Done.
//  - Add and Shift never asserted in the same cycle; at most one strobe per cycle.
//  - bit_cnt never exceeds WIDTH; no wrap. Holds last value in IDLE until next LOAD.
//  - rst mid-operation: next cycle IDLE, all outputs 0, no Done pulse.
//  - q0/q_zero ignored outside EVAL.
// CONFIGURATION
//  - SEQ_MULT_EARLY_TERM_EN defined:
//    EVAL checks q_zero=1 before q0 and goes directly to DONE.
//    bit_cnt keeps the partial count.
//    Done cycle = 3 + 2*k + popcount, k = index of highest set bit + 1 (0 if operand 0).
//  - Macro undefined: q_zero port present but unused; always WIDTH shifts.
// TESTING
//  - rst=1 with Start=1 for 2 cycles -> IDLE, all outputs 0, bit_cnt=0.
//  - WIDTH=8, mult=0x00, Start pulse -> Load cycle 1, 8 Shift, 0 Add,
//    Done cycle 19, bit_cnt=8.
//  - WIDTH=8, mult=0xFF -> 8 Add each followed by Shift, Done cycle 27.
//    Product 0xFF*0xFF=0xFE01 with datapath.
//  - WIDTH=8, mult=0xA5 -> Add count 4, Done cycle 23.
//    Start re-pulsed mid-run has no effect.
//  - rst asserted in cycle 6 of a 0xFF run -> IDLE next cycle, no Done.
//    New Start then yields a correct full run.
//  - EARLY_TERM_EN, mult=0x00 -> Done cycle 3, bit_cnt=0.
//    mult=0x01 -> Done cycle 6, bit_cnt=1.
//    Without macro, 0x01 -> Done cycle 20.

Source files
------------

// File: rtl/seq_mult_controller.sv
// Moore control FSM for a shift-add sequential multiplier: issues Load/Add/Shift strobes and counts bits.
// Optional early termination when the remaining multiplier bits are all zero: define SEQ_MULT_EARLY_TERM_EN.
module seq_mult_controller #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic             q0,
    input  logic             q_zero,
    output logic             Load,
    output logic             Add,
    output logic             Shift,
    output logic             Busy,
    output logic             Done,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [2:0]       fsm_state
);

    // Handshake: Start is a request taken only in IDLE (no queuing while Busy);
    // Done is a single-cycle completion pulse, after which IDLE may take a new Start.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_EVAL  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state == S_LOAD) begin
                cnt <= '0;
            end else if (state == S_SHIFT) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifndef SEQ_MULT_EARLY_TERM_EN
    logic unused_q_zero;
    assign unused_q_zero = q_zero;
`endif

    always_comb begin
        state_next = state;
        Load       = 1'b0;
        Add        = 1'b0;
        Shift      = 1'b0;
        Done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) state_next = S_LOAD;
            end
            S_LOAD: begin
                Load       = 1'b1;
                state_next = S_EVAL;
            end
            S_EVAL: begin
                // The datapath register was updated on the previous edge, so q0/q_zero are current here.
                if (cnt == CNT_W'(WIDTH)) begin
                    state_next = S_DONE;
`ifdef SEQ_MULT_EARLY_TERM_EN
                end else if (q_zero) begin
                    state_next = S_DONE;
`endif
                end else if (q0) begin
                    state_next = S_ADD;
                end else begin
                    state_next = S_SHIFT;
                end
            end
            S_ADD: begin
                Add        = 1'b1;
                state_next = S_SHIFT;
            end
            S_SHIFT: begin
                Shift      = 1'b1;
                state_next = S_EVAL;
            end
            S_DONE: begin
                Done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign Busy      = (state != S_IDLE);
    assign bit_cnt   = cnt;
    assign fsm_state = state;

endmodule

// File: tb/tb_seq_mult_controller.sv
// Bench for seq_mult_controller: a small shift-add datapath drives q0/q_zero, a run-level model
// predicts Load/Busy/Done timing, strobe counts and bit_cnt, and directed runs pin literal results.
module tb_seq_mult_controller;

    localparam int WIDTH = 8;

`ifdef SEQ_MULT_EARLY_TERM_EN
    localparam int DONE_00 = 3;
    localparam int DONE_01 = 6;
    localparam int DONE_03 = 9;
    localparam int CNT_00  = 0;
    localparam int CNT_01  = 1;
`else
    localparam int DONE_00 = 19;
    localparam int DONE_01 = 20;
    localparam int DONE_03 = 21;
    localparam int CNT_00  = 8;
    localparam int CNT_01  = 8;
`endif

    // ---------------- clock / reset ----------------
    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       Start = 1'b0;
    logic       q0;
    logic       q_zero;
    logic       Load, Add, Shift, Busy, Done;
    logic [3:0] bit_cnt;
    logic [2:0] fsm_state;

    always #5 clk = ~clk;

    seq_mult_controller #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .Start     (Start),
        .q0        (q0),
        .q_zero    (q_zero),
        .Load      (Load),
        .Add       (Add),
        .Shift     (Shift),
        .Busy      (Busy),
        .Done      (Done),
        .bit_cnt   (bit_cnt),
        .fsm_state (fsm_state)
    );

    // ---------------- datapath driven by the strobes ----------------
    logic [7:0] mult  = 8'h00;
    logic [7:0] mcand = 8'h00;
    logic [7:0] mq    = 8'h00;
    logic [7:0] acc   = 8'h00;
    logic [7:0] pq    = 8'h00;
    logic       carry = 1'b0;

    assign q0     = mq[0];
    assign q_zero = (mq == 8'h00);

    always @(posedge clk) begin
        if (rst) begin
            mq <= '0; acc <= '0; pq <= '0; carry <= 1'b0;
        end else if (Load) begin
            mq <= mult; pq <= mult; acc <= '0; carry <= 1'b0;
        end else if (Add) begin
            {carry, acc} <= {1'b0, acc} + {1'b0, mcand};
        end else if (Shift) begin
            carry <= 1'b0;
            acc   <= {carry, acc[7:1]};
            pq    <= {acc[0], pq[7:1]};
            mq    <= mq >> 1;
        end
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t, state=%0d)", name, act, exp, $time, fsm_state);
    endtask

    function automatic int popcount(input logic [7:0] m);
        int p = 0;
        for (int i = 0; i < WIDTH; i++) p += int'(m[i]);
        return p;
    endfunction

    // Number of multiplier bits the controller processes before Done.
    function automatic int bits_used(input logic [7:0] m);
`ifdef SEQ_MULT_EARLY_TERM_EN
        for (int i = WIDTH - 1; i >= 0; i--) if (m[i]) return i + 1;
        return 0;
`else
        return (m === m) ? WIDTH : WIDTH;
`endif
    endfunction

    // ---------------- run-level model and per-cycle compare ----------------
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    bit armed    = 1'b0;
    bit m_active = 1'b0;
    bit m_prev_add;
    int m_base, m_done, m_k, m_pop, m_adds, m_shifts, m_held;

    always @(negedge clk) begin
        bit just_done;
        int rel;
        just_done = 1'b0;
        if (armed) begin
            if (m_active) begin
                rel = edge_n - m_base;
                check("run_ctrl", {29'd0, Load, Busy, Done}, {29'd0, rel == 1, 1'b1, rel == m_done});
                check("strobe_excl", {31'd0, Add & Shift}, 32'd0);
                if (m_prev_add) check("add_then_shift", {31'd0, Shift}, 32'd1);
                check("cnt_bound", {31'd0, bit_cnt <= WIDTH}, 32'd1);
                m_adds     += int'(Add);
                m_shifts   += int'(Shift);
                m_prev_add  = Add;
                if (rel == m_done) begin
                    check("run_adds", m_adds, m_pop);
                    check("run_shifts", m_shifts, m_k);
                    check("run_bit_cnt", {28'd0, bit_cnt}, m_k);
                    m_held    = m_k;
                    m_active  = 1'b0;
                    just_done = 1'b1;
                end
            end else begin
                check("idle_outputs", {27'd0, Load, Add, Shift, Busy, Done}, 32'd0);
                check("idle_bit_cnt", {28'd0, bit_cnt}, m_held);
            end
        end
        if (rst) begin
            armed    = 1'b1;
            m_active = 1'b0;
            m_held   = 0;
        end else if (armed && !m_active && !just_done && Start) begin
            m_active   = 1'b1;
            m_base     = edge_n;
            m_k        = bits_used(mult);
            m_pop      = popcount(mult & 8'((1 << m_k) - 1));
            m_done     = 3 + 2 * m_k + m_pop;
            m_adds     = 0;
            m_shifts   = 0;
            m_prev_add = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_pulse(input logic [7:0] m, input logic [7:0] mc);
        @(posedge clk); #1;
        mult = m; mcand = mc; Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // Called in cycle 1 of a run; returns the cycle index of Done and Add count seen.
    task automatic run_to_done(input int repulse_at, output int c, output int adds);
        bit ok = 1'b0;
        c    = 1;
        adds = 0;
        for (int i = 0; i < 200; i++) begin
            adds += int'(Add);
            if (Done) begin ok = 1'b1; break; end
            if (c == repulse_at)     Start = 1'b1;
            if (c == repulse_at + 2) Start = 1'b0;
            @(posedge clk); #1;
            c++;
        end
        if (!ok) check("done_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed vectors ----------------
    initial begin
        int c, a;

        rst = 1'b1; Start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {27'd0, Load, Add, Shift, Busy, Done}, 32'd0);
        check("reset_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        rst = 1'b0; Start = 1'b0;
        repeat (2) @(posedge clk);

        start_pulse(8'h00, 8'h37);
        run_to_done(-10, c, a);
        check("done_cycle_00", c, DONE_00);
        check("adds_00", a, 0);
        check("bit_cnt_00", {28'd0, bit_cnt}, CNT_00);
        check("product_00", {acc, pq}, 32'h0000);

        start_pulse(8'hFF, 8'hFF);
        run_to_done(-10, c, a);
        check("done_cycle_ff", c, 27);
        check("adds_ff", a, 8);
        check("product_ff", {acc, pq}, 32'hFE01);

        start_pulse(8'hA5, 8'h3C);
        run_to_done(5, c, a);
        check("done_cycle_a5", c, 23);
        check("adds_a5", a, 4);
        check("product_a5", {acc, pq}, 32'h26AC);
        repeat (3) @(posedge clk);
        #1;
        check("a5_repulse_ignored", {31'd0, Busy}, 32'd0);

        start_pulse(8'h01, 8'h5A);
        run_to_done(-10, c, a);
        check("done_cycle_01", c, DONE_01);
        check("bit_cnt_01", {28'd0, bit_cnt}, CNT_01);
`ifndef SEQ_MULT_EARLY_TERM_EN
        check("product_01", {acc, pq}, 32'h005A);
`endif

        // Reset asserted in cycle 6 of a full-ones run aborts it with no Done.
        start_pulse(8'hFF, 8'hFF);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs", {27'd0, Load, Add, Shift, Busy, Done}, 32'd0);
        check("abort_bit_cnt", {28'd0, bit_cnt}, 32'd0);
        repeat (10) @(posedge clk);
        start_pulse(8'hFF, 8'hFF);
        run_to_done(-10, c, a);
        check("done_cycle_after_abort", c, 27);
        check("product_after_abort", {acc, pq}, 32'hFE01);

        // Start held high through Done restarts from the following IDLE cycle.
        @(posedge clk); #1;
        mult = 8'h03; mcand = 8'h11; Start = 1'b1;
        @(posedge clk); #1;
        run_to_done(-10, c, a);
        check("done_cycle_03", c, DONE_03);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("restart_load", {31'd0, Load}, 32'd1);
        Start = 1'b0;
        @(posedge clk); #1;
        run_to_done(-10, c, a);
        check("done_cycle_03_again", c, DONE_03 - 1);
`ifndef SEQ_MULT_EARLY_TERM_EN
        check("product_03", {acc, pq}, 32'h0033);
`endif

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
        $fatal(1, "watchdog");
    end

endmodule
